// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and helpers for the bit-serial adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to index WIDTH bit positions, never below 1
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Request/result bundle between a datapath and the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;

  // Requesting side
  modport master (
    output start_in, a_in, b_in, carry_in,
    input  busy_out, done_out, sum_out, carry_out
  );

  // Adder controller side
  modport slave (
    input  start_in, a_in, b_in, carry_in,
    output busy_out, done_out, sum_out, carry_out
  );
endinterface
`default_nettype wire

// File: rtl/fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_cell
// Description : Combinational 1-bit full adder shared by the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
  input  wire logic a_in,
  input  wire logic b_in,
  input  wire logic carry_in,
  output logic      sum_out,
  output logic      carry_out
);
  assign sum_out   = a_in ^ b_in ^ carry_in;
  assign carry_out = (a_in & b_in) | (a_in & carry_in) | (b_in & carry_in);
endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Adds two WIDTH-bit operands one bit per clock through a single
//               full-adder cell; reports the result with a one-cycle done.
//               WIDTH must match the WIDTH of the connected interface.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int            CW         = cnt_width(WIDTH);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_s_next;

  fa_cell u_fa (
    .a_in      (r_a[0]),
    .b_in      (r_b[0]),
    .carry_in  (r_carry),
    .sum_out   (w_s),
    .carry_out (w_c)
  );

  // The new sum bit enters at the MSB so after WIDTH shifts bit 0 lands at LSB
  assign w_s_next = {w_s, r_s[WIDTH-1:1]};

  // Control FSM, operand/sum shifters, carry register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start_in) begin
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_carry <= bus.carry_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_s     <= w_s_next;
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_c;
          if (r_cnt == C_CNT_LAST) begin
            // Counter is held on the last bit so it never wraps
            r_sum   <= w_s_next;
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_out  = r_busy;
  assign bus.done_out  = r_done;
  assign bus.sum_out   = r_sum;
  assign bus.carry_out = r_cout;

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands. It latches the operands on a start request, feeds one bit pair per clock through the cell, and holds the carry between cycles in a register. It reports the result with a one-cycle done pulse. It sits between a requesting datapath and the shared full-adder cell, trading latency for area.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_in  input  1  request to begin an addition; sampled only in IDLE.
- a_in  input  WIDTH  operand A; sampled on the accepting edge only.
- b_in  input  WIDTH  operand B; sampled on the accepting edge only.
- carry_in  input  1  initial carry; sampled on the accepting edge only.
- busy_out  output  1  high while in RUN.
- done_out  output  1  one-cycle pulse, high while in DONE.
- sum_out  output  WIDTH  registered result; holds its value until the next completion.
- carry_out  output  1  registered final carry; holds its value until the next completion.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start_in=1 at an edge:
  - load shift registers A and B from a_in and b_in;
  - load the carry register from carry_in;
  - clear bit counter cnt to 0;
  - go to RUN.
- IDLE, start_in=0: stay in IDLE.
- RUN, each edge:
  - full-adder cell computes (s, c) = A[0] + B[0] + carry;
  - s shifts into the MSB of sum shift register S, and S shifts right;
  - A and B shift right; carry ← c; cnt ← cnt+1.
- RUN, edge with cnt = WIDTH−1: perform the final shift, then:
  - sum_out ← final S;
  - carry_out ← final c;
  - go to DONE.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- start_in is ignored in RUN and DONE. No queuing: a request ignored there is lost.
- Result is exactly {carry_out, sum_out} = a_in + b_in + carry_in, with no truncation.
- cnt is $clog2(WIDTH) bits wide and never wraps during an operation.
- Reset mid-operation:
  - state goes to IDLE; the operation is aborted;
  - sum_out, carry_out and all internal registers clear to 0;
  - no done pulse is issued for the aborted operation.

## Timing
- Reset values: busy_out=0, done_out=0, sum_out=0, carry_out=0; state=IDLE; cnt=0.
- Start accepted at edge E0:
  - busy_out is high from after E0 through edge E0+WIDTH;
  - sum_out and carry_out update at edge E0+WIDTH;
  - done_out is high for the cycle between E0+WIDTH and E0+WIDTH+1.
- Latency: WIDTH cycles from the accepting edge to done_out.
- Throughput: one operation per WIDTH+2 cycles at most. The earliest next acceptance is edge E0+WIDTH+2.
- sum_out and carry_out are valid whenever done_out=1, and stable outside completion edges.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package serial_add_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the counter-width localparam function based on $clog2.
- One sub-module, fa_cell: a purely combinational 1-bit full adder.
  - Ports: a_in, b_in, carry_in, sum_out, carry_out.
  - Instantiated once.
- Control FSM, counter, and shift registers live in serial_adder_ctrl.

## Test plan
- WIDTH=8, a_in=8'h0F, b_in=8'h01, carry_in=0, start pulse → done_out exactly 8 cycles after the accepting edge; sum_out=8'h10, carry_out=0.
- a_in=8'hFF, b_in=8'h01, carry_in=0 → sum_out=8'h00, carry_out=1. a_in=8'hFF, b_in=8'hFF, carry_in=1 → sum_out=8'hFF, carry_out=1.
- Start with a_in=8'h12 and b_in=8'h34, then hold start_in=1 with different operands during RUN and DONE → exactly one done pulse with sum_out=8'h46. A new operation is accepted on the first IDLE cycle.
- Assert rst 4 cycles into an operation → all outputs 0 immediately (asynchronous); no done_out. A subsequent 8'h80+8'h80 gives sum_out=8'h00, carry_out=1.
- Random regression of 1000 operations against a golden model a+b+cin, checking for each operation:
  - busy_out duration equals WIDTH cycles;
  - done_out width equals 1 cycle;
  - sum_out is stable between completions.
